// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared mode type and width helper for the clock divider
package clk_div_pkg;
  typedef enum logic {MODE_TOGGLE = 1'b0, MODE_PULSE = 1'b1} mode_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with active/shadow config and boundary-only commit
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int W           = 19,
  parameter int DEFAULT_DIV = 400000
) (
  input  logic         cin,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sync,
  input  logic         wr,
  input  logic [W-1:0] wdiv,
  input  mode_t        wmode,
  output logic         pend,
  output logic         cout
);
  logic [W-1:0] cnt, div_a, div_s;
  mode_t mode_a, mode_s;
  logic idle, tc, commit;
  assign idle   = !en || div_a == '0;
  assign tc     = !idle && cnt == div_a - W'(1);
  assign commit = pend && (tc || idle || sync);
  // wr only arrives while pend is clear, so it never collides with commit
  always_ff @(posedge cin or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      cout   <= 1'b0;
      pend   <= 1'b0;
      div_a  <= W'(DEFAULT_DIV);
      div_s  <= W'(DEFAULT_DIV);
      mode_a <= MODE_TOGGLE;
      mode_s <= MODE_TOGGLE;
    end else begin
      if (wr) begin
        div_s  <= wdiv;
        mode_s <= wmode;
      end
      pend <= wr ? 1'b1 : commit ? 1'b0 : pend;
      if (commit) begin
        div_a  <= div_s;
        mode_a <= mode_s;
      end
      cnt  <= (commit || sync || idle || tc) ? '0 : cnt + W'(1);
      cout <= (commit || sync || idle) ? 1'b0 :
              tc ? (mode_a == MODE_PULSE || !cout) : (mode_a == MODE_TOGGLE && cout);
    end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N-channel programmable clock divider with per-channel config handshake
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N           = 4,
  parameter int W           = 19,
  parameter int DEFAULT_DIV = 400000,
  localparam int CW         = clog2(N) > 0 ? clog2(N) : 1
) (
  input  logic          cin,
  input  logic          rst_n,
  input  logic [N-1:0]  en,
  input  logic          sync,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_div,
  input  logic          cfg_mode,
  output logic [N-1:0]  cout
);
  logic [N-1:0] sel, pend;
  // an out-of-range channel selects nothing, so it reads ready and is dropped
  assign cfg_ready = !(|(sel & pend));
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign sel[i] = cfg_ch == CW'(i);
    clk_div_chan #(.W(W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .cin   (cin),
      .rst_n (rst_n),
      .en    (en[i]),
      .sync  (sync),
      .wr    (cfg_valid && cfg_ready && sel[i]),
      .wdiv  (cfg_div),
      .wmode (mode_t'(cfg_mode)),
      .pend  (pend[i]),
      .cout  (cout[i])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed table plus hand sequences for sync, parking and async reset
module tb_clk_div_multi;
  logic       cin = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en = 4'hF;
  logic       sync = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = 2'd2;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_mode = 1'b0;
  logic [3:0] cout;
  int checks = 0;
  int errors = 0;

  clk_div_multi #(.N(4), .W(8), .DEFAULT_DIV(4)) dut (
    .cin(cin), .rst_n(rst_n), .en(en), .sync(sync), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cout(cout)
  );

  always #5 cin = ~cin;

  typedef struct {
    logic [3:0] en;
    logic       cv;
    logic [1:0] ch;
    logic [7:0] div;
    logic       md;
    logic       rdy;
    logic [3:0] cout;
  } vec_t;
  vec_t tv[32];
  logic [3:0] exp_c[32] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0,
                            4'h0, 4'h0, 4'h0, 4'hD, 4'hD, 4'hD, 4'hF, 4'h0,
                            4'h0, 4'h2, 4'h0, 4'hD, 4'hF, 4'hD, 4'hD, 4'h0,
                            4'h0, 4'h0, 4'h0, 4'hD, 4'hD, 4'hD, 4'hF, 4'h0};
  logic [3:0] exp_r[8] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
  logic [3:0] exp_t[4] = '{4'h0, 4'h1, 4'h0, 4'h1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] e, input logic s, input logic cv, input logic [1:0] ch,
                       input logic [7:0] d, input logic md);
    en = e; sync = s; cfg_valid = cv; cfg_ch = ch; cfg_div = d; cfg_mode = md;
    #1;
  endtask

  task automatic edge_tick();
    @(posedge cin);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) tv[k] = '{4'hF, 1'b0, 2'd2, 8'd0, 1'b0, 1'b1, exp_c[k]};
    tv[9]  = '{4'hF, 1'b1, 2'd1, 8'd3, 1'b1, 1'b1, exp_c[9]};
    tv[10] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 1'b0, exp_c[10]};
    tv[11] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 1'b0, exp_c[11]};
    tv[12] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 1'b1, exp_c[12]};
    tv[21] = '{4'hF, 1'b1, 2'd1, 8'd2, 1'b0, 1'b1, exp_c[21]};
    tv[22] = '{4'hF, 1'b1, 2'd1, 8'd5, 1'b1, 1'b0, exp_c[22]};
    tv[23] = '{4'hF, 1'b1, 2'd1, 8'd5, 1'b1, 1'b0, exp_c[23]};
    tv[24] = '{4'hF, 1'b1, 2'd1, 8'd5, 1'b1, 1'b1, exp_c[24]};
    // reset state
    repeat (2) @(posedge cin);
    #1;
    chk("reset_cout", 32'(cout), 32'h0);
    chk("reset_ready", 32'(cfg_ready), 32'h1);
    rst_n = 1'b1;
    // table: default divide-by-4 toggle, ch1 reconfig, held second request
    for (int k = 0; k < 32; k++) begin
      drive(tv[k].en, 1'b0, tv[k].cv, tv[k].ch, tv[k].div, tv[k].md);
      chk($sformatf("tbl_ready_%0d", k + 1), 32'(cfg_ready), 32'(tv[k].rdy));
      edge_tick();
      chk($sformatf("tbl_cout_%0d", k + 1), 32'(cout), 32'(tv[k].cout));
    end
    // ch2 parked with D=0, then D=1 toggle
    drive(4'hF, 1'b0, 1'b1, 2'd2, 8'd0, 1'b0);
    chk("park_ready_accept", 32'(cfg_ready), 32'h1);
    edge_tick();
    for (int k = 0; k < 3; k++) begin
      drive(4'hF, 1'b0, 1'b0, 2'd2, 8'd0, 1'b0);
      chk($sformatf("park_ready_busy_%0d", k), 32'(cfg_ready), 32'h0);
      edge_tick();
    end
    drive(4'hF, 1'b0, 1'b0, 2'd2, 8'd0, 1'b0);
    chk("park_ready_done", 32'(cfg_ready), 32'h1);
    for (int k = 0; k < 4; k++) begin
      edge_tick();
      chk($sformatf("park_cout_%0d", k), 32'(cout[2]), 32'h0);
      chk($sformatf("park_cnt_%0d", k), 32'(dut.g_ch[2].u_ch.cnt), 32'h0);
    end
    drive(4'hF, 1'b0, 1'b1, 2'd2, 8'd1, 1'b0);
    chk("d1_ready", 32'(cfg_ready), 32'h1);
    edge_tick();
    drive(4'hF, 1'b0, 1'b0, 2'd2, 8'd0, 1'b0);
    chk("d1_cout_pre", 32'(cout[2]), 32'h0);
    for (int k = 0; k < 4; k++) begin
      edge_tick();
      chk($sformatf("d1_cout_%0d", k), 32'(cout[2]), 32'(exp_t[k]));
    end
    // sync on ch0's terminal count realigns ch0 and ch3
    drive(4'hF, 1'b1, 1'b0, 2'd2, 8'd0, 1'b0);
    edge_tick();
    drive(4'h7, 1'b0, 1'b0, 2'd2, 8'd0, 1'b0);
    edge_tick();
    drive(4'hF, 1'b0, 1'b0, 2'd2, 8'd0, 1'b0);
    repeat (2) edge_tick();
    chk("phase_cnt0", 32'(dut.g_ch[0].u_ch.cnt), 32'h3);
    chk("phase_cnt3", 32'(dut.g_ch[3].u_ch.cnt), 32'h2);
    drive(4'hF, 1'b1, 1'b0, 2'd2, 8'd0, 1'b0);
    edge_tick();
    drive(4'hF, 1'b0, 1'b0, 2'd2, 8'd0, 1'b0);
    chk("sync_cout", 32'({cout[3], cout[0]}), 32'h0);
    chk("sync_cnt0", 32'(dut.g_ch[0].u_ch.cnt), 32'h0);
    chk("sync_cnt3", 32'(dut.g_ch[3].u_ch.cnt), 32'h0);
    for (int k = 0; k < 4; k++) begin
      edge_tick();
      chk($sformatf("sync_run_%0d", k), 32'({cout[3], cout[0]}), k == 3 ? 32'h3 : 32'h0);
    end
    // async reset mid-period with ch1 pending
    drive(4'hF, 1'b0, 1'b1, 2'd1, 8'd7, 1'b1);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);
    edge_tick();
    drive(4'hF, 1'b0, 1'b0, 2'd1, 8'd0, 1'b0);
    chk("rst_pend", 32'(cfg_ready), 32'h0);
    chk("rst_pre_cout", 32'({cout[3], cout[0]}), 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_cout", 32'(cout), 32'h0);
    chk("rst_async_ready", 32'(cfg_ready), 32'h1);
    repeat (2) @(posedge cin);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(4'hF, 1'b0, 1'b0, 2'd1, 8'd0, 1'b0);
      edge_tick();
      chk($sformatf("post_rst_%0d", k), 32'(cout), 32'(exp_r[k]));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
